// File: rtl/uart_rx_ctrl.sv
// Capture/buffer controller for the oversampling UART receiver: one capture per
// finish-flag rising edge, FWFT FIFO to the consumer, sticky overflow and idle timeout.
module uart_rx_ctrl #(
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 3,
  parameter int IDLE_CYCLES = 2048
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_done,
  input  logic [7:0]       rx_data,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] fifo_count,
  output logic             byte_strobe,
  output logic             overflow,
  input  logic             clr_overflow,
  output logic             idle
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IDL_W = $clog2(IDLE_CYCLES + 1);

  // state | meaning
  // HOLD  | finish flag may still be high from a captured (or pre-reset) byte
  // ARMED | flag seen low; next high level is a new byte
  typedef enum logic {
    ST_HOLD  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_capture;

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             r_strobe;
  logic [IDL_W-1:0] r_idle_cnt;

  logic w_full;
  logic w_rd_en;
  logic w_wr_en;
  logic w_drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_HOLD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      ST_HOLD: begin
        if (!rx_done) begin
          w_state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (rx_done) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      default: w_state_nxt = ST_HOLD;
    endcase
  end

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_rd_en = (r_count != '0) && m_ready;
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign w_wr_en = w_capture && (!w_full || w_rd_en);
  assign w_drop  = w_capture && w_full && !w_rd_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr] <= rx_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_strobe   <= 1'b0;
      r_idle_cnt <= '0;
    end else begin
      r_strobe <= w_capture;
      if (w_capture) begin
        r_idle_cnt <= '0;
      end else if (r_idle_cnt != IDL_W'(IDLE_CYCLES)) begin
        r_idle_cnt <= r_idle_cnt + IDL_W'(1);
      end
    end
  end

  assign m_data      = r_mem[r_rd_ptr];
  assign m_valid     = (r_count != '0);
  assign fifo_count  = r_count;
  assign byte_strobe = r_strobe;
  assign overflow    = r_overflow;
  assign idle        = (r_idle_cnt == IDL_W'(IDLE_CYCLES));

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl (DEPTH=4, IDLE_CYCLES=16); expected values hand-derived.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_done;
  logic [7:0] rx_data;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [2:0] fifo_count;
  logic       byte_strobe;
  logic       overflow;
  logic       clr_overflow;
  logic       idle;

  int n_chk  = 0;
  int n_pass = 0;
  int n_strb = 0;

  uart_rx_ctrl #(.DEPTH(4), .CNT_W(3), .IDLE_CYCLES(16)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .rx_done      (rx_done),
    .rx_data      (rx_data),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .fifo_count   (fifo_count),
    .byte_strobe  (byte_strobe),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .idle         (idle)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (byte_strobe) n_strb++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    rx_data = d;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] exp_q [4];
    rst          = 1'b1;
    rx_done      = 1'b1;
    rx_data      = 8'h5A;
    m_ready      = 1'b0;
    clr_overflow = 1'b0;
    tick(2);
    chk("rst_count",    32'(fifo_count),  32'd0);
    chk("rst_valid",    32'(m_valid),     32'd0);
    chk("rst_data",     32'(m_data),      32'h00);
    chk("rst_strobe",   32'(byte_strobe), 32'd0);
    chk("rst_overflow", 32'(overflow),    32'd0);
    chk("rst_idle",     32'(idle),        32'd0);

    // Stale finish flag across reset must not be captured
    rst = 1'b0;
    tick(50);
    chk("stale_strobes", 32'(n_strb),  32'd0);
    chk("stale_valid",   32'(m_valid), 32'd0);
    chk("stale_idle",    32'(idle),    32'd1);
    rx_done = 1'b0;
    tick();
    rx_data = 8'hA5;
    rx_done = 1'b1;
    tick();
    chk("t1_valid",  32'(m_valid),     32'd1);
    chk("t1_data",   32'(m_data),      32'hA5);
    chk("t1_count",  32'(fifo_count),  32'd1);
    chk("t1_strobe", 32'(byte_strobe), 32'd1);
    chk("t1_idle",   32'(idle),        32'd0);

    // Held flag: one capture only
    tick(300);
    chk("t2_strobes", 32'(n_strb),     32'd1);
    chk("t2_count",   32'(fifo_count), 32'd1);
    rx_done = 1'b0;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("t2_pop_count", 32'(fifo_count), 32'd0);
    chk("t2_pop_valid", 32'(m_valid),    32'd0);
    m_ready = 1'b1;
    tick(2);
    m_ready = 1'b0;
    chk("empty_pop_count", 32'(fifo_count), 32'd0);

    // Overflow on fifth byte
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    chk("t3_count",    32'(fifo_count), 32'd4);
    chk("t3_overflow", 32'(overflow),   32'd1);
    chk("t3_strobes",  32'(n_strb),     32'd6);
    m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("t3_drain_valid", 32'(m_valid), 32'd1);
      chk("t3_drain_data",  32'(m_data),  32'(i));
      tick();
    end
    m_ready = 1'b0;
    chk("t3_empty_valid", 32'(m_valid),  32'd0);
    chk("t3_ovf_sticky",  32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("t3_ovf_clr", 32'(overflow), 32'd0);

    // Push and pop on the same edge while full
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
    chk("t4_full", 32'(fifo_count), 32'd4);
    rx_data = 8'h77;
    rx_done = 1'b1;
    m_ready = 1'b1;
    tick();
    rx_done = 1'b0;
    m_ready = 1'b0;
    chk("t4_count",    32'(fifo_count), 32'd4);
    chk("t4_overflow", 32'(overflow),   32'd0);
    tick();
    exp_q = '{8'h11, 8'h12, 8'h13, 8'h77};
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_drain_data", 32'(m_data), 32'(exp_q[i]));
      tick();
    end
    m_ready = 1'b0;
    chk("t4_empty_valid", 32'(m_valid), 32'd0);

    // Idle threshold boundary: counter 0 at capture edge, 16 edges later idle
    tick(20);
    chk("t5_idle_set", 32'(idle), 32'd1);
    rx_data = 8'h42;
    rx_done = 1'b1;
    tick();
    chk("t5_idle_clr", 32'(idle), 32'd0);
    rx_done = 1'b0;
    tick(15);
    chk("t5_idle_15", 32'(idle), 32'd0);
    tick();
    chk("t5_idle_16", 32'(idle), 32'd1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;

    // Async reset with three entries queued
    for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i));
    chk("t5_q3", 32'(fifo_count), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_count", 32'(fifo_count), 32'd0);
    chk("t5_rst_valid", 32'(m_valid),    32'd0);
    chk("t5_rst_data",  32'(m_data),     32'h00);
    tick();
    rst = 1'b0;
    tick();
    send_byte(8'h3C);
    chk("post_rst_count", 32'(fifo_count), 32'd1);
    chk("post_rst_data",  32'(m_data),     32'h3C);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
